// File: rtl/stream_mux2_arb_if.sv
// Handshake bundle for the two-source stream arbiter: A/B request streams in,
// merged Y stream out, plus lock status.
interface stream_mux2_arb_if #(
  parameter int unsigned WIDTH = 8
);
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] a_data;
  logic             a_last;
  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_last;
  logic             y_valid;
  logic             y_ready;
  logic [WIDTH-1:0] y_data;
  logic             y_sel;
  logic             busy;

  // Arbiter side.
  modport slave (
    input  a_valid, a_data, a_last, b_valid, b_data, b_last, y_ready,
    output a_ready, b_ready, y_valid, y_data, y_sel, busy
  );

  // Producer/consumer side.
  modport master (
    output a_valid, a_data, a_last, b_valid, b_data, b_last, y_ready,
    input  a_ready, b_ready, y_valid, y_data, y_sel, busy
  );
endinterface

// File: rtl/stream_mux2_arb.sv
// Two-input packet arbiter: round-robin between packets, grant held until the
// last beat, selected beat lands in a single registered output stage.
module stream_mux2_arb #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned PRIORITY_INIT = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  stream_mux2_arb_if.slave     bus
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StLockA = 2'd1;
  localparam logic [1:0] StLockB = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             rr_q, rr_d;
  logic             y_valid_q, y_valid_d;
  logic [WIDTH-1:0] y_data_q, y_data_d;
  logic             y_sel_q, y_sel_d;

  logic grant_a, grant_b;
  logic can_load;
  logic acc_a, acc_b;

  // IDLE grant is combinational on the current valids so packets go back to back.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    unique case (state_q)
      StLockA: grant_a = 1'b1;
      StLockB: grant_b = 1'b1;
      default: begin
        if (bus.a_valid && bus.b_valid) begin
          grant_a = !rr_q;
          grant_b = rr_q;
        end else begin
          grant_a = bus.a_valid;
          grant_b = bus.b_valid;
        end
      end
    endcase
  end

  assign can_load    = !y_valid_q || bus.y_ready;
  assign bus.a_ready = grant_a && can_load;
  assign bus.b_ready = grant_b && can_load;
  assign acc_a       = bus.a_valid && bus.a_ready;
  assign acc_b       = bus.b_valid && bus.b_ready;

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    y_valid_d = y_valid_q;
    y_data_d  = y_data_q;
    y_sel_d   = y_sel_q;
    if (acc_a) begin
      y_valid_d = 1'b1;
      y_data_d  = bus.a_data;
      y_sel_d   = 1'b0;
      if (bus.a_last) begin
        state_d = StIdle;
        rr_d    = 1'b1;
      end else begin
        state_d = StLockA;
      end
    end else if (acc_b) begin
      y_valid_d = 1'b1;
      y_data_d  = bus.b_data;
      y_sel_d   = 1'b1;
      if (bus.b_last) begin
        state_d = StIdle;
        rr_d    = 1'b0;
      end else begin
        state_d = StLockB;
      end
    end else if (bus.y_ready) begin
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      rr_q      <= (PRIORITY_INIT != 0);
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
      y_sel_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      y_valid_q <= y_valid_d;
      y_data_q  <= y_data_d;
      y_sel_q   <= y_sel_d;
    end
  end

  assign bus.y_valid = y_valid_q;
  assign bus.y_data  = y_data_q;
  assign bus.y_sel   = y_sel_q;
  assign bus.busy    = (state_q != StIdle);

endmodule

// File: tb/tb_stream_mux2_arb.sv
// Bench for stream_mux2_arb: directed scenarios plus random traffic, all
// checked against a packet-level reference model and an output scoreboard.
module tb_stream_mux2_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_mux2_arb_if #(.WIDTH(8)) bus ();

  stream_mux2_arb #(.WIDTH(8), .PRIORITY_INIT(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: who owns the output (0 none, 1 A, 2 B), who is preferred
  // on contention, and what the output register should currently show.
  int         m_owner;
  logic       m_pref;
  logic       m_yv;
  logic [7:0] m_yd;
  logic       m_ys;
  logic [8:0] sb_q[$];  // {sel, data} of accepted beats not yet delivered

  logic       obs_ar, obs_br, obs_yv, obs_ys, obs_busy;
  logic [7:0] obs_yd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0;
    m_pref  = 1'b0;
    m_yv    = 1'b0;
    m_yd    = 8'h00;
    m_ys    = 1'b0;
    sb_q.delete();
  endtask

  task automatic drive_idle();
    bus.a_valid = 1'b0; bus.a_data = 8'h00; bus.a_last = 1'b0;
    bus.b_valid = 1'b0; bus.b_data = 8'h00; bus.b_last = 1'b0;
    bus.y_ready = 1'b0;
  endtask

  // Asserts reset asynchronously at the current time, checks it, releases on a negedge.
  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    #1;
    check("rst_y_valid", 32'(bus.y_valid), 32'd0);
    check("rst_y_data",  32'(bus.y_data),  32'd0);
    check("rst_y_sel",   32'(bus.y_sel),   32'd0);
    check("rst_busy",    32'(bus.busy),    32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle: apply inputs, compare against the model, advance the model.
  task automatic step(input logic av, input logic [7:0] ad, input logic al,
                      input logic bv, input logic [7:0] bd, input logic bl,
                      input logic yr);
    logic ga, gb, can, acc_a, acc_b;
    logic [8:0] front;
    @(negedge clk);
    bus.a_valid = av; bus.a_data = ad; bus.a_last = al;
    bus.b_valid = bv; bus.b_data = bd; bus.b_last = bl;
    bus.y_ready = yr;
    #1;
    obs_ar = bus.a_ready; obs_br = bus.b_ready; obs_yv = bus.y_valid;
    obs_yd = bus.y_data;  obs_ys = bus.y_sel;   obs_busy = bus.busy;

    ga = 1'b0; gb = 1'b0;
    if (m_owner == 1) ga = 1'b1;
    else if (m_owner == 2) gb = 1'b1;
    else if (av && bv) begin ga = !m_pref; gb = m_pref; end
    else begin ga = av; gb = bv; end
    can = !m_yv || yr;

    check("a_ready", 32'(obs_ar),   32'(ga && can));
    check("b_ready", 32'(obs_br),   32'(gb && can));
    check("y_valid", 32'(obs_yv),   32'(m_yv));
    check("y_data",  32'(obs_yd),   32'(m_yd));
    check("y_sel",   32'(obs_ys),   32'(m_ys));
    check("busy",    32'(obs_busy), 32'(m_owner != 0));

    if (obs_yv && yr) begin
      if (sb_q.size() == 0) begin
        check("sb_spurious_beat", 32'(obs_yd), 32'hffff_ffff);
      end else begin
        front = sb_q.pop_front();
        check("sb_beat", {23'd0, obs_ys, obs_yd}, 32'(front));
      end
    end

    acc_a = av && ga && can;
    acc_b = bv && gb && can;
    if (acc_a) begin
      m_yv = 1'b1; m_yd = ad; m_ys = 1'b0;
      sb_q.push_back({1'b0, ad});
      if (al) begin m_owner = 0; m_pref = 1'b1; end else m_owner = 1;
    end else if (acc_b) begin
      m_yv = 1'b1; m_yd = bd; m_ys = 1'b1;
      sb_q.push_back({1'b1, bd});
      if (bl) begin m_owner = 0; m_pref = 1'b0; end else m_owner = 2;
    end else if (yr) begin
      m_yv = 1'b0;
    end
  endtask

  logic [7:0] got_y[6];

  initial begin
    int na, nb;
    drive_idle();
    model_reset();
    #2;
    do_reset();

    // Single beat from A.
    step(1'b1, 8'h3C, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    check("single_a_ready", 32'(obs_ar), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("single_y_valid", 32'(obs_yv), 32'd1);
    check("single_y_data",  32'(obs_yd), 32'h3C);
    check("single_y_sel",   32'(obs_ys), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("single_drain", 32'(obs_yv), 32'd0);

    // Round-robin with single-beat packets from both sides.
    @(negedge clk); #2; do_reset();
    na = 0; nb = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'(8'hA0 + na), 1'b1, 1'b1, 8'(8'hB0 + nb), 1'b1, 1'b1);
      if (obs_ar) na++;
      if (obs_br) nb++;
      got_y[i] = obs_yd;
      if (i > 0) check("rr_no_bubble", 32'(obs_yv), 32'd1);
    end
    check("rr_y1", 32'(got_y[1]), 32'hA0);
    check("rr_y2", 32'(got_y[2]), 32'hB0);
    check("rr_y3", 32'(got_y[3]), 32'hA1);
    check("rr_y4", 32'(got_y[4]), 32'hB1);

    // Packet lock: three-beat A packet, B waiting with a single beat.
    @(negedge clk); #2; do_reset();
    step(1'b1, 8'h11, 1'b0, 1'b1, 8'h44, 1'b1, 1'b1);
    check("lock_b_ready0", 32'(obs_br), 32'd0);
    step(1'b1, 8'h22, 1'b0, 1'b1, 8'h44, 1'b1, 1'b1);
    check("lock_b_ready1", 32'(obs_br), 32'd0);
    check("lock_busy1", 32'(obs_busy), 32'd1);
    got_y[1] = obs_yd;
    step(1'b1, 8'h33, 1'b1, 1'b1, 8'h44, 1'b1, 1'b1);
    check("lock_b_ready2", 32'(obs_br), 32'd0);
    check("lock_busy2", 32'(obs_busy), 32'd1);
    got_y[2] = obs_yd;
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'h44, 1'b1, 1'b1);
    check("lock_b_ready3", 32'(obs_br), 32'd1);
    got_y[3] = obs_yd;
    step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    got_y[4] = obs_yd;
    check("lock_y1", 32'(got_y[1]), 32'h11);
    check("lock_y2", 32'(got_y[2]), 32'h22);
    check("lock_y3", 32'(got_y[3]), 32'h33);
    check("lock_y4", 32'(got_y[4]), 32'h44);

    // Backpressure with both requesters valid.
    @(negedge clk); #2; do_reset();
    step(1'b1, 8'h22, 1'b1, 1'b1, 8'h55, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h23, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0);
      check("bp_y_data", 32'(obs_yd), 32'h22);
      check("bp_y_sel",  32'(obs_ys), 32'd0);
      check("bp_ready",  32'({obs_ar, obs_br}), 32'd0);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'h55, 1'b1, 1'b1);
    check("bp_resume_b", 32'(obs_br), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("bp_next_data", 32'(obs_yd), 32'h55);
    check("bp_next_sel",  32'(obs_ys), 32'd1);

    // Lock held across a gap in A's valid.
    @(negedge clk); #2; do_reset();
    step(1'b1, 8'h10, 1'b0, 1'b1, 8'h66, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b1, 8'h66, 1'b1, 1'b1);
      check("gap_b_blocked", 32'(obs_br), 32'd0);
      check("gap_busy", 32'(obs_busy), 32'd1);
    end
    step(1'b1, 8'h20, 1'b1, 1'b1, 8'h66, 1'b1, 1'b1);
    check("gap_b_blocked_last", 32'(obs_br), 32'd0);
    check("gap_a_last_ready", 32'(obs_ar), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'h66, 1'b1, 1'b1);
    check("gap_b_granted", 32'(obs_br), 32'd1);
    check("gap_y_20", 32'(obs_yd), 32'h20);

    // Asynchronous reset in the middle of a three-beat A packet.
    @(negedge clk); #2; do_reset();
    step(1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h02, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    @(posedge clk); #2;
    do_reset();
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b1);
    check("rst_b_first", 32'(obs_br), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("rst_b_sel", 32'(obs_ys), 32'd1);
    check("rst_b_data", 32'(obs_yd), 32'h5A);

    // Random traffic.
    @(negedge clk); #2; do_reset();
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stream_mux2_arb.md
Name: stream_mux2_arb

Overview:
- Two-input, one-output stream arbiter that controls a shared 2:1 mux datapath.
- Two requesters (A and B) each present valid/ready/data/last streams. The block grants one requester at a time, using round-robin between packets.
- A grant is held until the granted packet's last beat is accepted.
- The selected beat is driven into a single registered output stage. It sits in front of any consumer that receives merged traffic from two producers.

Parameters:
- WIDTH, 8, data width of a_data, b_data and y_data.
- PRIORITY_INIT, 0, requester preferred on the first contended arbitration after reset (0 = A, 1 = B).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a_valid  in  1  requester A beat valid.
- a_ready  out  1  A beat accepted when a_valid & a_ready.
- a_data  in  WIDTH  requester A payload.
- a_last  in  1  final beat of A packet.
- b_valid  in  1  requester B beat valid.
- b_ready  out  1  B beat accepted when b_valid & b_ready.
- b_data  in  WIDTH  requester B payload.
- b_last  in  1  final beat of B packet.
- y_valid  out  1  output beat valid (registered).
- y_ready  in  1  consumer ready.
- y_data  out  WIDTH  output payload (registered).
- y_sel  out  1  source of the current y beat (0 = A, 1 = B), registered; this is the mux select.
- busy  out  1  high while a packet lock is held (state != IDLE).

Behaviour:
- Reset: one clock, clk. Reset is asynchronous and active-low on rst_n. While rst_n = 0:
  - y_valid = 0, y_data = 0, y_sel = 0, busy = 0.
  - State = IDLE, rr_ptr = PRIORITY_INIT.
  - Asserting reset mid-packet abandons the packet; the in-flight output beat is dropped.
- State machine: IDLE, LOCK_A, LOCK_B.
- Grant (combinational):
  - LOCK_A grants A; LOCK_B grants B.
  - In IDLE: if only one of a_valid/b_valid is high, grant that requester. If both are high, grant rr_ptr. If neither is high, no grant.
- Load condition: can_load = !y_valid | y_ready.
- Ready signals: a_ready = grant_A & can_load; b_ready = grant_B & can_load.
  - The ungranted requester's ready is always 0.
  - In IDLE, ready may depend on the same-cycle valid.
- Accept: a beat is accepted on valid & ready. On accept, at the next edge: y_valid <= 1, y_data <= source data, y_sel <= source.
- Drain: if there is no accept and y_ready = 1, then y_valid <= 0. y_data and y_sel hold their values.
- Transitions on an accepted beat from source S:
  - last = 0: state <= LOCK_S (remains LOCK_S if already there).
  - last = 1: state <= IDLE, rr_ptr <= other source.
- Without an accept, state and rr_ptr hold. In LOCK_S, a valid from the other source is ignored (ready = 0).
- Latency: one cycle from accept to y_valid.
- Throughput: one beat per cycle while y_ready = 1. There is no bubble between packets: the IDLE grant is combinational, so a new packet can be accepted in the cycle after the previous last beat.
- Output hold: while y_valid = 1 & y_ready = 0, y_data and y_sel are stable. No beat is lost or duplicated.
- Single-beat packets (last = 1 on the first beat) never enter LOCK.
- The granted requester dropping valid mid-packet keeps the lock; no other traffic passes until its last beat.

Test Plan:
- Reset: drive rst_n = 0 asynchronously between edges during a 3-beat A packet. Required: y_valid = 0, y_data = 0, busy = 0 immediately. After release, a B single beat 0x5A is accepted first cycle, and y_sel = 1 on the next cycle.
- Single beat: a_valid = 1, a_data = 0x3C, a_last = 1, y_ready = 1, B idle. Required: a_ready = 1 same cycle. Next cycle: y_valid = 1, y_data = 0x3C, y_sel = 0. One cycle later y_valid = 0.
- Round-robin, PRIORITY_INIT = 0: A and B continuously valid with single-beat packets (A = 0xA0.., B = 0xB0..), y_ready = 1. Required: y_sel sequence 0,1,0,1; y_data sequence A0, B0, A1, B1; no idle cycles.
- Packet lock: A sends 0x11, 0x22, 0x33 (last on 0x33); B holds 0x44 last = 1 from cycle 0. Required: y_data = 11, 22, 33, 44 on consecutive cycles; b_ready = 0 for the first 3 cycles; busy high during the A packet.
- Backpressure: y_ready = 0 for 3 cycles with y_valid = 1, y_data = 0x22 and both requesters valid. Required: y_data/y_sel stable, a_ready = b_ready = 0. After y_ready = 1, the beat sequence continues with no loss or duplication.
- Lock with gap: A sends non-last 0x10, drops a_valid 2 cycles, then sends 0x20 last. B is valid throughout. Required: b_ready = 0 until 0x20 is accepted; then B is granted.
